// File: rtl/vec_alu_pipe_if.sv
`default_nettype none
// ============================================================================
// vec_alu_pipe_if : operand/result handshake bundle for vec_alu_pipe
// Rev 1.0
// ============================================================================
interface vec_alu_pipe_if #(
  parameter int LANES = 4,
  parameter int LW    = 8
) ();
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [LANES*LW-1:0]   v1_i;
  logic [LANES*LW-1:0]   v2_i;
  logic [2:0]            op_i;
  logic                  sat_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [LANES*LW-1:0]   v_o;
  logic [LANES-1:0]      ovf_o;

  modport master (
    output in_valid_i, v1_i, v2_i, op_i, sat_i, out_ready_i,
    input  in_ready_o, out_valid_o, v_o, ovf_o
  );

  modport slave (
    input  in_valid_i, v1_i, v2_i, op_i, sat_i, out_ready_i,
    output in_ready_o, out_valid_o, v_o, ovf_o
  );
endinterface
`default_nettype wire

// File: rtl/vec_alu_pipe.sv
`default_nettype none
// ============================================================================
// vec_alu_pipe : two-stage packed-SIMD ALU with overflow/saturation and a
//                dot-product accumulator, valid/ready on both sides
// Rev 1.0
// ============================================================================
module vec_alu_pipe #(
  parameter int LANES = 4,
  parameter int LW    = 8,
  parameter int ACC_W = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  vec_alu_pipe_if.slave bus
);
  localparam int c_VW    = LANES * LW;
  localparam int c_LW1   = LW + 1;
  localparam int c_PW    = 2 * LW;
  localparam int c_DPW   = c_PW + $clog2(LANES);
  localparam int c_AW1   = ACC_W + 1;
  localparam int c_LANES = LANES;

  localparam logic [2:0] c_OP_VADD = 3'b010;
  localparam logic [2:0] c_OP_VSUB = 3'b110;
  localparam logic [2:0] c_OP_VDP  = 3'b001;
  localparam logic [2:0] c_OP_VMAC = 3'b011;
  localparam logic [2:0] c_OP_VCLR = 3'b100;

  logic w_adv;
  logic w_is_sub;

  logic signed [LW:0]     w_lane_res [LANES];
  logic signed [c_PW-1:0] w_prod     [LANES];

  logic                   r_s1_valid;
  logic                   r_s1_sat;
  logic [2:0]             r_s1_op;
  logic [c_VW-1:0]        r_s1_v1;
  logic signed [LW:0]     r_s1_lane  [LANES];
  logic signed [c_PW-1:0] r_s1_prod  [LANES];

  logic                   r_out_valid;
  logic [c_VW-1:0]        r_v;
  logic [LANES-1:0]       r_ovf;
  logic signed [ACC_W-1:0] r_acc;

  logic [c_VW-1:0]         w_lane_pack;
  logic [LANES-1:0]        w_lane_ovf;
  logic signed [c_DPW-1:0] w_dot;
  logic signed [ACC_W:0]   w_acc_sum;
  logic                    w_acc_ovf;
  logic signed [ACC_W-1:0] w_acc_mac;
  logic [c_VW-1:0]         w_v_next;
  logic [LANES-1:0]        w_ovf_next;
  logic signed [ACC_W-1:0] w_acc_d;

  assign w_adv           = !r_out_valid || bus.out_ready_i;
  assign bus.in_ready_o  = w_adv;
  assign bus.out_valid_o = r_out_valid;
  assign bus.v_o         = r_v;
  assign bus.ovf_o       = r_ovf;

  assign w_is_sub = (bus.op_i == c_OP_VSUB);

  // Stage 1: exact per-lane sum/difference and full-width products.
  for (genvar k = 0; k < LANES; k++) begin : g_s1_lane
    logic signed [LW-1:0] w_a;
    logic signed [LW-1:0] w_b;
    assign w_a = bus.v1_i[k*LW +: LW];
    assign w_b = bus.v2_i[k*LW +: LW];
    assign w_lane_res[k] = w_is_sub ? (c_LW1'(w_a) - c_LW1'(w_b))
                                    : (c_LW1'(w_a) + c_LW1'(w_b));
    assign w_prod[k] = c_PW'(w_a) * c_PW'(w_b);
  end

  // Stage 2 lanes: overflow is a disagreement between the two top bits.
  for (genvar k = 0; k < LANES; k++) begin : g_s2_lane
    logic w_ovf;
    assign w_ovf         = r_s1_lane[k][LW] ^ r_s1_lane[k][LW-1];
    assign w_lane_ovf[k] = w_ovf;
    assign w_lane_pack[k*LW +: LW] = (w_ovf && r_s1_sat)
        ? {r_s1_lane[k][LW], {(LW-1){~r_s1_lane[k][LW]}}}
        : r_s1_lane[k][LW-1:0];
  end

  always_comb begin
    w_dot = '0;
    for (int k = 0; k < LANES; k++) begin
      w_dot = w_dot + c_DPW'(r_s1_prod[k]);
    end
  end

  assign w_acc_sum = c_AW1'(r_acc) + c_AW1'(w_dot);
  assign w_acc_ovf = w_acc_sum[ACC_W] ^ w_acc_sum[ACC_W-1];
  assign w_acc_mac = (w_acc_ovf && r_s1_sat)
      ? {w_acc_sum[ACC_W], {(ACC_W-1){~w_acc_sum[ACC_W]}}}
      : w_acc_sum[ACC_W-1:0];

  always_comb begin
    w_v_next   = r_s1_v1;
    w_ovf_next = '0;
    w_acc_d    = r_acc;
    case (r_s1_op)
      c_OP_VADD, c_OP_VSUB: begin
        w_v_next   = w_lane_pack;
        w_ovf_next = w_lane_ovf;
      end
      c_OP_VDP: begin
        w_v_next = c_VW'(w_dot);
      end
      c_OP_VMAC: begin
        w_acc_d    = w_acc_mac;
        w_v_next   = c_VW'(w_acc_mac);
        w_ovf_next = c_LANES'(w_acc_ovf);
      end
      c_OP_VCLR: begin
        w_acc_d  = '0;
        w_v_next = '0;
      end
      default: ;
    endcase
  end

  // Both stages move together; the accumulator updates on the S2 load edge,
  // so a following VMAC in S1 always sees the fresh value.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_s1_valid  <= 1'b0;
      r_s1_sat    <= 1'b0;
      r_s1_op     <= '0;
      r_s1_v1     <= '0;
      for (int k = 0; k < LANES; k++) begin
        r_s1_lane[k] <= '0;
        r_s1_prod[k] <= '0;
      end
      r_out_valid <= 1'b0;
      r_v         <= '0;
      r_ovf       <= '0;
      r_acc       <= '0;
    end else if (w_adv) begin
      r_s1_valid <= bus.in_valid_i;
      if (bus.in_valid_i) begin
        r_s1_sat <= bus.sat_i;
        r_s1_op  <= bus.op_i;
        r_s1_v1  <= bus.v1_i;
        for (int k = 0; k < LANES; k++) begin
          r_s1_lane[k] <= w_lane_res[k];
          r_s1_prod[k] <= w_prod[k];
        end
      end
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_v   <= w_v_next;
        r_ovf <= w_ovf_next;
        r_acc <= w_acc_d;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_vec_alu_pipe.sv
`default_nettype none
// ============================================================================
// tb_vec_alu_pipe : directed vectors with a queue scoreboard for vec_alu_pipe
// Rev 1.0
// ============================================================================
module tb_vec_alu_pipe;
  localparam int LANES = 4;
  localparam int LW    = 8;
  localparam int ACC_W = 32;

  localparam logic [2:0] c_OP_VADD = 3'b010;
  localparam logic [2:0] c_OP_VSUB = 3'b110;
  localparam logic [2:0] c_OP_VDP  = 3'b001;
  localparam logic [2:0] c_OP_VMAC = 3'b011;
  localparam logic [2:0] c_OP_VCLR = 3'b100;
  localparam logic [2:0] c_OP_PASS = 3'b111;

  typedef struct packed {
    logic [31:0] v;
    logic [3:0]  ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  vec_alu_pipe_if #(.LANES(LANES), .LW(LW)) bus ();

  vec_alu_pipe #(.LANES(LANES), .LW(LW), .ACC_W(ACC_W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: a result retires on the next edge when valid&ready hold now.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid_o && bus.out_ready_i) begin
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL sb_unexpected: got v=0x%0h with nothing expected", bus.v_o);
      end else begin
        e = sb_q.pop_front();
        check("sb_v",   64'(bus.v_o),   64'(e.v));
        check("sb_ovf", 64'(bus.ovf_o), 64'(e.ovf));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic sat, input exp_t e);
    bit done;
    done = 1'b0;
    bus.in_valid_i = 1'b1;
    bus.op_i       = op;
    bus.v1_i       = a;
    bus.v2_i       = b;
    bus.sat_i      = sat;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = bus.in_ready_o && rst_n;
      step();
    end
    bus.in_valid_i = 1'b0;
    if (done) sb_q.push_back(e);
    else begin
      n_total++;
      $display("FAIL issue_timeout: op=%b not accepted, expected acceptance within 50 cycles", op);
    end
  endtask

  task automatic drain();
    bus.in_valid_i = 1'b0;
    for (int i = 0; i < 20 && (sb_q.size() != 0 || bus.out_valid_o); i++) step();
    if (sb_q.size() != 0 || bus.out_valid_o) begin
      n_total++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb_q.size());
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n           = 1'b0;
    bus.in_valid_i  = 1'b1;
    bus.op_i        = c_OP_VADD;
    bus.v1_i        = 32'h7F7F7F7F;
    bus.v2_i        = 32'h01010101;
    bus.sat_i       = 1'b0;
    bus.out_ready_i = 1'b1;

    // Reset with input valid held high
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_out_valid", 64'(bus.out_valid_o), 64'h0);
      check("rst_v",         64'(bus.v_o),         64'h0);
      check("rst_ovf",       64'(bus.ovf_o),       64'h0);
    end
    rst_n          = 1'b1;
    bus.in_valid_i = 1'b0;

    issue(c_OP_VMAC, 32'h01010101, 32'h01010101, 1'b0, exp_t'{v: 32'h4, ovf: 4'h0});
    drain();

    // VADD wrap with latency probe, then saturate
    issue(c_OP_VADD, 32'h7F018005, 32'h0101FF03, 1'b0, exp_t'{v: 32'h80027F08, ovf: 4'b1010});
    check("lat_first_edge", 64'(bus.out_valid_o), 64'h0);
    step();
    check("lat_second_edge", 64'(bus.out_valid_o), 64'h1);
    drain();
    issue(c_OP_VADD, 32'h7F018005, 32'h0101FF03, 1'b1, exp_t'{v: 32'h7F028008, ovf: 4'b1010});
    issue(c_OP_VSUB, 32'h00000080, 32'h00000001, 1'b1, exp_t'{v: 32'h00000080, ovf: 4'b0001});
    issue(c_OP_VSUB, 32'h00000005, 32'h00000003, 1'b1, exp_t'{v: 32'h00000002, ovf: 4'b0000});
    issue(c_OP_PASS, 32'hDEADBEEF, 32'h12345678, 1'b1, exp_t'{v: 32'hDEADBEEF, ovf: 4'b0000});

    // Dot product leaves the accumulator (4) alone
    issue(c_OP_VDP,  32'h02030405, 32'h01FF0203, 1'b0, exp_t'{v: 32'h00000016, ovf: 4'h0});
    issue(c_OP_VDP,  32'h80808080, 32'h7F7F7F7F, 1'b0, exp_t'{v: 32'hFFFF0200, ovf: 4'h0});
    issue(c_OP_VMAC, 32'h02030405, 32'h01FF0203, 1'b0, exp_t'{v: 32'h0000001A, ovf: 4'h0});

    // Back-to-back accumulate after clear
    issue(c_OP_VCLR, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, exp_t'{v: 32'h0, ovf: 4'h0});
    issue(c_OP_VMAC, 32'h02030405, 32'h01FF0203, 1'b0, exp_t'{v: 32'h16, ovf: 4'h0});
    issue(c_OP_VMAC, 32'h02030405, 32'h01FF0203, 1'b0, exp_t'{v: 32'h2C, ovf: 4'h0});
    issue(c_OP_VMAC, 32'h02030405, 32'h01FF0203, 1'b0, exp_t'{v: 32'h42, ovf: 4'h0});
    drain();

    // Walk the accumulator to 0x80000000 (wrapping), then down to 0x7FFFFFF0
    issue(c_OP_VCLR, 32'h0, 32'h0, 1'b0, exp_t'{v: 32'h0, ovf: 4'h0});
    for (int i = 1; i <= 32768; i++) begin
      issue(c_OP_VMAC, 32'h80808080, 32'h80808080, 1'b0,
            exp_t'{v: 32'(i) << 16, ovf: (i == 32768) ? 4'h1 : 4'h0});
    end
    issue(c_OP_VMAC, 32'h000000FC, 32'h00000004, 1'b0, exp_t'{v: 32'h7FFFFFF0, ovf: 4'h1});
    issue(c_OP_VMAC, 32'h02030405, 32'h01FF0203, 1'b1, exp_t'{v: 32'h7FFFFFFF, ovf: 4'h1});
    drain();

    // Backpressure: the third op must wait while outputs stay frozen
    bus.out_ready_i = 1'b0;
    issue(c_OP_PASS, 32'h11111111, 32'h0, 1'b0, exp_t'{v: 32'h11111111, ovf: 4'h0});
    issue(c_OP_VADD, 32'h01020304, 32'h01010101, 1'b0, exp_t'{v: 32'h02030405, ovf: 4'h0});
    bus.in_valid_i = 1'b1;
    bus.op_i       = c_OP_VSUB;
    bus.v1_i       = 32'h10101010;
    bus.v2_i       = 32'h01010101;
    for (int i = 0; i < 5; i++) begin
      check("stall_in_ready", 64'(bus.in_ready_o), 64'h0);
      check("stall_v",        64'(bus.v_o),        64'h11111111);
      check("stall_ovf",      64'(bus.ovf_o),      64'h0);
      step();
    end
    bus.out_ready_i = 1'b1;
    issue(c_OP_VSUB, 32'h10101010, 32'h01010101, 1'b0, exp_t'{v: 32'h0F0F0F0F, ovf: 4'h0});
    drain();

    // Reset during a stall drops everything in flight
    bus.out_ready_i = 1'b0;
    issue(c_OP_PASS, 32'hAAAAAAAA, 32'h0, 1'b0, exp_t'{v: 32'hAAAAAAAA, ovf: 4'h0});
    issue(c_OP_PASS, 32'h55555555, 32'h0, 1'b0, exp_t'{v: 32'h55555555, ovf: 4'h0});
    step();
    rst_n = 1'b0;
    sb_q.delete();
    step();
    check("midrst_out_valid", 64'(bus.out_valid_o), 64'h0);
    check("midrst_v",         64'(bus.v_o),         64'h0);
    check("midrst_ovf",       64'(bus.ovf_o),       64'h0);
    rst_n           = 1'b1;
    bus.out_ready_i = 1'b1;
    step();
    check("midrst_dropped", 64'(bus.out_valid_o), 64'h0);
    issue(c_OP_VMAC, 32'h01010101, 32'h01010101, 1'b0, exp_t'{v: 32'h4, ovf: 4'h0});
    drain();

    check("sb_empty", 64'(sb_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/vec_alu_pipe.md
Name: vec_alu_pipe

Overview:
Pipelined, parametrised packed-SIMD vector ALU, successor to the single-cycle combinational 4x8-bit vector ALU in the execute path.
- Generalised in lane count and lane width.
- Adds true signed-overflow detection, an optional saturation mode, and a multi-cycle dot-product accumulate held in an internal accumulator.
- Sits between operand read and writeback.
- Uses a valid/ready handshake on both sides, so the execute stage can stall it.

Parameters:
LANES, 4, number of packed lanes (>=2)
LW, 8, lane width in bits (>=4)
ACC_W, 32, accumulator width; must satisfy 2*LW+clog2(LANES) <= ACC_W <= LANES*LW

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  synchronous active-low reset
in_valid_i  in  1  operands/op valid
in_ready_o  out  1  block can accept this cycle
v1_i  in  LANES*LW  operand 1, lane k = bits [k*LW +: LW], two's complement
v2_i  in  LANES*LW  operand 2, same packing
op_i  in  3  010 VADD, 110 VSUB, 001 VDP, 011 VMAC, 100 VCLR, others PASS
sat_i  in  1  saturate lane results (VADD/VSUB) and the accumulator (VMAC)
out_valid_o  out  1  result valid
out_ready_i  in  1  consumer accepts result
v_o  out  LANES*LW  result
ovf_o  out  LANES  per-lane signed-overflow flags

Behaviour:
- Reset (rst_ni=0 at a clock edge): out_valid_o=0, v_o=0, ovf_o=0, accumulator=0, stage-1 valid=0. In-flight operations are discarded.
- Two register stages. S1 captures the operands and computes the lane sums/differences or the lane products. S2 does the reduction/accumulate and drives the outputs.
- Global advance: adv = !out_valid_o | out_ready_i.
  - in_ready_o = adv (combinational).
  - A transfer occurs when in_valid_i & in_ready_o.
  - When adv=0, both stages hold and the outputs stay stable.
- Latency is 2 cycles from the accepting edge to out_valid_o=1 when there is no backpressure. Throughput is 1 op/cycle.
- VADD/VSUB:
  - Each lane is computed at LW+1 bits.
  - ovf_o[k] = 1 iff the exact result lies outside [-2^(LW-1), 2^(LW-1)-1].
  - sat_i=0: the lane wraps (low LW bits).
  - sat_i=1: the lane clamps to the nearest bound.
  - ovf_o is reported in both modes.
- VDP:
  - Products are computed at 2*LW bits signed and summed exactly.
  - v_o = the sum sign-extended to LANES*LW. ovf_o=0. The accumulator is untouched.
- VMAC:
  - acc_next = acc + dot(v1,v2), computed at ACC_W+1 bits. The accumulator is updated on the same edge that loads S2.
  - sat_i=0: wrap modulo 2^ACC_W. sat_i=1: clamp to the signed ACC_W range.
  - ovf_o[0] = accumulator overflow for this op; other bits are 0.
  - v_o = acc_next sign-extended.
  - Back-to-back VMACs chain with no bubble; each sees the previous op's result.
- VCLR: the accumulator becomes 0 when the op loads S2. v_o=0, ovf_o=0.
- PASS (any other encoding): v_o=v1_i, ovf_o=0, accumulator untouched.
- sat_i is ignored for VDP, VCLR and PASS.
- Simultaneous accept and output retire: both happen in the same cycle; no bubble.
- in_valid_i=0 while adv=1: a bubble propagates and out_valid_o drops after it.

Test Plan:
1. Reset: drive rst_ni=0 for 2 cycles with in_valid_i=1 -> out_valid_o=0, v_o=0, ovf_o=0. Then a VMAC with v1=v2=0x01010101 -> v_o=4, i.e. the accumulator started at 0.
2. VADD, sat_i=0, v1=0x7F018005, v2=0x0101FF03 -> v_o=0x80027F08, ovf_o=4'b1010, out_valid_o exactly 2 cycles after accept. Same op with sat_i=1 -> v_o=0x7F028008, ovf_o=4'b1010.
3. VSUB, sat_i=1, v1=0x00000080, v2=0x00000001 -> lane0=0x80, ovf_o[0]=1. VSUB with v1=0x00000005, v2=0x00000003 -> v_o=0x00000002, ovf_o=0.
4. VDP, v1=0x02030405, v2=0x01FF0203 -> v_o=0x00000016. A following VMAC confirms the accumulator is unchanged.
5. VCLR, then three back-to-back VMACs with the operands of scenario 4 -> v_o=0x16, 0x2C, 0x42 on consecutive cycles. With ACC_W=32, pre-load the accumulator via VMACs to 0x7FFFFFF0, then VMAC +0x16 with sat_i=1 -> v_o=0x7FFFFFFF, ovf_o[0]=1.
6. Backpressure: hold out_ready_i=0 for 5 cycles while issuing 3 ops -> in_ready_o=0 once the pipeline is full, v_o/ovf_o stable throughout. Release -> results emerge in order with none lost or duplicated. Assert rst_ni mid-stall -> outputs cleared and in-flight ops dropped.
